// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED blinker; a shared prescaler makes a one-cycle
//    tick, and each channel has its own mode/period register set through a write port.
// Latency: a write shows on LEDR one edge after the accept edge; tick is registered.
// Backpressure: wr_ready = ~tick, so writes are refused in tick cycles and the master holds wr_en.
// Ports:
//    CLOCK_50, reset        clock and synchronous active-high reset
//    wr_en/wr_ch/wr_mode/   configuration write (mode 00 OFF, 01 ON, 10 BLINK, 11 FLASH;
//    wr_period/wr_ready     period in ticks, 0 halts the channel)
//    sync                   only with `define BLINK_SYNC_EN: realigns every channel to phase 0
//    tick                   one-cycle prescaler pulse
//    LEDR                   registered LED outputs, one bit per channel
module led_blink_multi #(
   parameter int CHANNELS       = 10,
   parameter int PRESCALE       = 50000,
   parameter int PERIOD_W       = 10,
   parameter int DEFAULT_PERIOD = 250,
   localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [1:0]          wr_mode,
   input  logic [PERIOD_W-1:0] wr_period,
`ifdef BLINK_SYNC_EN
   input  logic                sync,
`endif
   output logic                wr_ready,
   output logic                tick,
   output logic [CHANNELS-1:0] LEDR
);

   localparam int P_W = $clog2(PRESCALE);
   localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;

   logic [P_W-1:0]      p;
   logic [1:0]          mode   [CHANNELS];
   logic [PERIOD_W-1:0] period [CHANNELS];
   logic [PERIOD_W-1:0] cnt    [CHANNELS];
   logic [CHANNELS-1:0] phase;
   logic [CHANNELS-1:0] led_fn;
   logic                accept;
   logic                sync_now;

`ifdef BLINK_SYNC_EN
   assign sync_now = sync;
`else
   assign sync_now = 1'b0;
`endif

   // Writes never coincide with a channel advance because both are gated by tick.
   assign wr_ready = ~tick;
   assign accept   = wr_en & wr_ready;

   always_comb begin
      led_fn = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (mode[i])
            MODE_OFF:   led_fn[i] = 1'b0;
            MODE_ON:    led_fn[i] = 1'b1;
            MODE_BLINK: led_fn[i] = phase[i];
            // FLASH: one tick out of every period, silent while halted
            default:    led_fn[i] = (cnt[i] == '0) && (period[i] != '0);
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         p     <= '0;
         tick  <= 1'b0;
         LEDR  <= '0;
         phase <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mode[i]   <= MODE_BLINK;
            period[i] <= PERIOD_W'(DEFAULT_PERIOD);
            cnt[i]    <= '0;
         end
      end else begin
         LEDR <= led_fn;
         if (sync_now) begin
            // Realign: restart the prescaler and all channel phases; a write here is dropped.
            p     <= '0;
            tick  <= 1'b0;
            phase <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
               cnt[i] <= '0;
            end
         end else begin
            if (p == P_LAST) begin
               p    <= '0;
               tick <= 1'b1;
            end else begin
               p    <= p + 1'b1;
               tick <= 1'b0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
               // Out-of-range wr_ch matches no channel, so it is accepted and ignored.
               if (accept && (int'(wr_ch) == i)) begin
                  mode[i]   <= wr_mode;
                  period[i] <= wr_period;
                  cnt[i]    <= '0;
                  phase[i]  <= 1'b0;
               end else if (tick && (period[i] != '0)) begin
                  // >= keeps cnt < period, so the +1 below can never overflow
                  if (cnt[i] >= period[i] - PERIOD_W'(1)) begin
                     cnt[i]   <= '0;
                     phase[i] <= ~phase[i];
                  end else begin
                     cnt[i] <= cnt[i] + PERIOD_W'(1);
                  end
               end
            end
         end
      end
   end

endmodule
